// File: rtl/voice_allocator_if.sv
// Event/voice bus between the MIDI decoder, the voice allocator and the voice bank.
//
// master : event source and voice-bank side (drives events, observes voices)
// slave  : voice_allocator side
//
// Signals:
//   event_valid/event_ready     handshake for one note event
//   event_on/note/velocity      event payload (velocity ignored for note-off)
//   all_notes_off               level request to release every voice
//   voice_active/note/velocity  per-voice state, voice i packed at i*WIDTH
//   voice_trigger/release       one-cycle envelope pulses per voice
//   steal                       one-cycle pulse when an active voice was overwritten
interface voice_allocator_if #(
    parameter int unsigned VOICE_COUNT    = 8,
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7
);
    logic                                  event_valid;
    logic                                  event_ready;
    logic                                  event_on;
    logic [NOTE_WIDTH-1:0]                 event_note;
    logic [VELOCITY_WIDTH-1:0]             event_velocity;
    logic                                  all_notes_off;
    logic [VOICE_COUNT-1:0]                voice_active;
    logic [VOICE_COUNT*NOTE_WIDTH-1:0]     voice_note;
    logic [VOICE_COUNT*VELOCITY_WIDTH-1:0] voice_velocity;
    logic [VOICE_COUNT-1:0]                voice_trigger;
    logic [VOICE_COUNT-1:0]                voice_release;
    logic                                  steal;

    modport master (
        output event_valid,
        output event_on,
        output event_note,
        output event_velocity,
        output all_notes_off,
        input  event_ready,
        input  voice_active,
        input  voice_note,
        input  voice_velocity,
        input  voice_trigger,
        input  voice_release,
        input  steal
    );

    modport slave (
        input  event_valid,
        input  event_on,
        input  event_note,
        input  event_velocity,
        input  all_notes_off,
        output event_ready,
        output voice_active,
        output voice_note,
        output voice_velocity,
        output voice_trigger,
        output voice_release,
        output steal
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: assigns note-on/note-off events to a bank of VOICE_COUNT voices,
// reusing a voice already playing the note, else the lowest free voice, else stealing the
// least recently assigned voice.
//
// Ports:
//   clock_50_000_000  system clock, rising edge
//   reset_l           asynchronous active-low reset
//   bus_io            voice_allocator_if.slave: event handshake, all_notes_off, voice outputs
//
// Each accepted event is processed in IDLE -> SCAN (one voice per cycle) -> APPLY, so
// results appear VOICE_COUNT+1 edges after acceptance. all_notes_off overrides everything.
module voice_allocator #(
    parameter int unsigned VOICE_COUNT    = 8,
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7
) (
    input  logic             clock_50_000_000,
    input  logic             reset_l,
    voice_allocator_if.slave bus_io
);

    localparam int unsigned IdxW = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;

    typedef logic [IdxW-1:0]           idx_t;
    typedef logic [NOTE_WIDTH-1:0]     note_t;
    typedef logic [VELOCITY_WIDTH-1:0] vel_t;

    localparam idx_t LastIdx = idx_t'(VOICE_COUNT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StApply
    } state_e;

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;

    // Latched event
    logic   ev_on_q, ev_on_d;
    note_t  ev_note_q, ev_note_d;
    vel_t   ev_vel_q, ev_vel_d;

    // Scan results
    logic   match_vld_q, match_vld_d;
    idx_t   match_idx_q, match_idx_d;
    logic   free_vld_q, free_vld_d;
    idx_t   free_idx_q, free_idx_d;
    idx_t   oldest_idx_q, oldest_idx_d;

    // Voice bank state
    logic [VOICE_COUNT-1:0] active_q, active_d;
    logic [VOICE_COUNT-1:0] trigger_q, trigger_d;
    logic [VOICE_COUNT-1:0] release_q, release_d;
    logic                   steal_q, steal_d;
    note_t                  note_q [VOICE_COUNT];
    note_t                  note_d [VOICE_COUNT];
    vel_t                   vel_q  [VOICE_COUNT];
    vel_t                   vel_d  [VOICE_COUNT];
    // Age rank: 0 = most recently assigned, VOICE_COUNT-1 = oldest; always a permutation
    idx_t                   age_q  [VOICE_COUNT];
    idx_t                   age_d  [VOICE_COUNT];

    logic ready;
    logic accept;
    idx_t apply_tgt;

    logic [VOICE_COUNT*NOTE_WIDTH-1:0]     note_flat;
    logic [VOICE_COUNT*VELOCITY_WIDTH-1:0] vel_flat;

    assign ready  = (state_q == StIdle) && !bus_io.all_notes_off;
    assign accept = ready && bus_io.event_valid;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ev_on_d      = ev_on_q;
        ev_note_d    = ev_note_q;
        ev_vel_d     = ev_vel_q;
        match_vld_d  = match_vld_q;
        match_idx_d  = match_idx_q;
        free_vld_d   = free_vld_q;
        free_idx_d   = free_idx_q;
        oldest_idx_d = oldest_idx_q;
        active_d     = active_q;
        trigger_d    = '0;
        release_d    = '0;
        steal_d      = 1'b0;
        note_d       = note_q;
        vel_d        = vel_q;
        age_d        = age_q;
        apply_tgt    = '0;

        if (bus_io.all_notes_off) begin
            // Release pulses only for voices still active, so a held level pulses once.
            state_d   = StIdle;
            release_d = active_q;
            active_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d     = StScan;
                        idx_d       = '0;
                        // Velocity-0 note-on is a note-off by MIDI convention.
                        ev_on_d     = bus_io.event_on && (bus_io.event_velocity != '0);
                        ev_note_d   = bus_io.event_note;
                        ev_vel_d    = bus_io.event_velocity;
                        match_vld_d = 1'b0;
                        free_vld_d  = 1'b0;
                    end
                end

                StScan: begin
                    if (!match_vld_q && active_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
                        match_vld_d = 1'b1;
                        match_idx_d = idx_q;
                    end
                    if (!free_vld_q && !active_q[idx_q]) begin
                        free_vld_d = 1'b1;
                        free_idx_d = idx_q;
                    end
                    if (age_q[idx_q] == LastIdx) begin
                        oldest_idx_d = idx_q;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StApply;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end

                StApply: begin
                    state_d = StIdle;
                    if (ev_on_q) begin
                        if (match_vld_q) begin
                            apply_tgt = match_idx_q;
                        end else if (free_vld_q) begin
                            apply_tgt = free_idx_q;
                        end else begin
                            apply_tgt = oldest_idx_q;
                            steal_d   = 1'b1;
                        end
                        active_d[apply_tgt]  = 1'b1;
                        note_d[apply_tgt]    = ev_note_q;
                        vel_d[apply_tgt]     = ev_vel_q;
                        trigger_d[apply_tgt] = 1'b1;
                        // Move the target to the youngest rank, shifting younger voices back.
                        for (int unsigned j = 0; j < VOICE_COUNT; j++) begin
                            if (age_q[j] < age_q[apply_tgt]) begin
                                age_d[j] = age_q[j] + idx_t'(1);
                            end
                        end
                        age_d[apply_tgt] = '0;
                    end else if (match_vld_q) begin
                        active_d[match_idx_q]  = 1'b0;
                        release_d[match_idx_q] = 1'b1;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            ev_vel_q     <= '0;
            match_vld_q  <= 1'b0;
            match_idx_q  <= '0;
            free_vld_q   <= 1'b0;
            free_idx_q   <= '0;
            oldest_idx_q <= '0;
            active_q     <= '0;
            trigger_q    <= '0;
            release_q    <= '0;
            steal_q      <= 1'b0;
            for (int unsigned i = 0; i < VOICE_COUNT; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= idx_t'(i);
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ev_on_q      <= ev_on_d;
            ev_note_q    <= ev_note_d;
            ev_vel_q     <= ev_vel_d;
            match_vld_q  <= match_vld_d;
            match_idx_q  <= match_idx_d;
            free_vld_q   <= free_vld_d;
            free_idx_q   <= free_idx_d;
            oldest_idx_q <= oldest_idx_d;
            active_q     <= active_d;
            trigger_q    <= trigger_d;
            release_q    <= release_d;
            steal_q      <= steal_d;
            for (int unsigned i = 0; i < VOICE_COUNT; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    always_comb begin
        note_flat = '0;
        vel_flat  = '0;
        for (int unsigned i = 0; i < VOICE_COUNT; i++) begin
            note_flat[i*NOTE_WIDTH +: NOTE_WIDTH]         = note_q[i];
            vel_flat[i*VELOCITY_WIDTH +: VELOCITY_WIDTH]  = vel_q[i];
        end
    end

    assign bus_io.event_ready    = ready;
    assign bus_io.voice_active   = active_q;
    assign bus_io.voice_note     = note_flat;
    assign bus_io.voice_velocity = vel_flat;
    assign bus_io.voice_trigger  = trigger_q;
    assign bus_io.voice_release  = release_q;
    assign bus_io.steal          = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator with VOICE_COUNT=4.
// A per-cycle model (voice arrays, LRU list, busy countdown) is compared against the DUT on
// every falling edge; directed scenarios add literal expectations at key points.
module tb_voice_allocator;

    localparam int VC = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    voice_allocator_if #(
        .VOICE_COUNT   (VC),
        .NOTE_WIDTH    (NW),
        .VELOCITY_WIDTH(VW)
    ) vif ();

    voice_allocator #(
        .VOICE_COUNT   (VC),
        .NOTE_WIDTH    (NW),
        .VELOCITY_WIDTH(VW)
    ) dut (
        .clock_50_000_000(clk),
        .reset_l         (rst_l),
        .bus_io          (vif)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic          m_act  [VC];
    int            m_note [VC];
    int            m_vel  [VC];
    int            lru[$];   // voice indices, most recently assigned first
    int            busy;     // edges remaining until the pending event takes effect
    logic          p_on;
    int            p_note;
    int            p_vel;
    logic [VC-1:0] x_trig;
    logic [VC-1:0] x_rel;
    logic          x_steal;

    function automatic void model_reset();
        lru.delete();
        for (int i = 0; i < VC; i++) begin
            m_act[i]  = 1'b0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            lru.push_back(i);
        end
        busy    = 0;
        x_trig  = '0;
        x_rel   = '0;
        x_steal = 1'b0;
    endfunction

    function automatic void model_apply();
        int   t;
        logic stole;
        t     = -1;
        stole = 1'b0;
        for (int i = 0; i < VC; i++) begin
            if (t < 0 && m_act[i] && m_note[i] == p_note) t = i;
        end
        if (p_on) begin
            for (int i = 0; i < VC; i++) begin
                if (t < 0 && !m_act[i]) t = i;
            end
            if (t < 0) begin
                t     = lru[lru.size() - 1];
                stole = 1'b1;
            end
            m_act[t]  = 1'b1;
            m_note[t] = p_note;
            m_vel[t]  = p_vel;
            x_trig[t] = 1'b1;
            x_steal   = stole;
            for (int k = 0; k < lru.size(); k++) begin
                if (lru[k] == t) begin
                    lru.delete(k);
                    break;
                end
            end
            lru.push_front(t);
        end else if (t >= 0) begin
            m_act[t] = 1'b0;
            x_rel[t] = 1'b1;
        end
    endfunction

    // Predict the effect of the upcoming rising edge from the inputs now stable.
    function automatic void model_step();
        x_trig  = '0;
        x_rel   = '0;
        x_steal = 1'b0;
        if (vif.all_notes_off) begin
            for (int i = 0; i < VC; i++) begin
                x_rel[i] = m_act[i];
                m_act[i] = 1'b0;
            end
            busy = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) model_apply();
        end else if (vif.event_valid) begin
            p_on   = vif.event_on && (vif.event_velocity != '0);
            p_note = int'(vif.event_note);
            p_vel  = int'(vif.event_velocity);
            busy   = VC + 1;
        end
    endfunction

    always @(negedge clk) begin : cmp
        logic [VC-1:0]    ea;
        logic [VC*NW-1:0] en;
        logic [VC*VW-1:0] ev;
        logic             er;
        if (!rst_l) model_reset();
        for (int i = 0; i < VC; i++) begin
            ea[i]          = m_act[i];
            en[i*NW +: NW] = NW'(m_note[i]);
            ev[i*VW +: VW] = VW'(m_vel[i]);
        end
        er = (busy == 0) && !vif.all_notes_off;
        check("cyc_voice_active",   64'(vif.voice_active),   64'(ea));
        check("cyc_voice_note",     64'(vif.voice_note),     64'(en));
        check("cyc_voice_velocity", 64'(vif.voice_velocity), 64'(ev));
        check("cyc_voice_trigger",  64'(vif.voice_trigger),  64'(x_trig));
        check("cyc_voice_release",  64'(vif.voice_release),  64'(x_rel));
        check("cyc_steal",          64'(vif.steal),          64'(x_steal));
        check("cyc_event_ready",    64'(vif.event_ready),    64'(er));
        if (rst_l) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic on, input int note, input int vel);
        vif.event_valid    = 1'b1;
        vif.event_on       = on;
        vif.event_note     = NW'(note);
        vif.event_velocity = VW'(vel);
    endtask

    // Called just after a rising edge with an event driven; returns just after acceptance.
    task automatic wait_accept();
        int   n;
        logic rdy;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            rdy = vif.event_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
            n++;
        end
        vif.event_valid = 1'b0;
        check("event_accepted", 64'(got), 64'(1));
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (vif.event_ready !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic send(input logic on, input int note, input int vel, output int lat);
        drive(on, note, vel);
        wait_accept();
        wait_ready(lat);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_l = 1'b0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int            lat;
        logic [VC-1:0] trig_seen;

        vif.event_valid    = 1'b0;
        vif.event_on       = 1'b0;
        vif.event_note     = '0;
        vif.event_velocity = '0;
        vif.all_notes_off  = 1'b0;
        rst_l              = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_active", 64'(vif.voice_active), 64'(0));
        check("rst_ready",  64'(vif.event_ready),  64'(1));
        rst_l = 1'b1;

        // First note lands on voice 0, VOICE_COUNT+1 edges after acceptance.
        send(1'b1, 60, 100, lat);
        check("first_latency",  64'(lat),                         64'(5));
        check("first_trigger",  64'(vif.voice_trigger),           64'(4'b0001));
        check("first_active",   64'(vif.voice_active),            64'(4'b0001));
        check("first_note",     64'(vif.voice_note[NW-1:0]),      64'(60));
        check("first_velocity", 64'(vif.voice_velocity[VW-1:0]),  64'(100));
        @(posedge clk);
        #1;
        check("first_trigger_gone", 64'(vif.voice_trigger), 64'(0));

        // Fill all four voices, fifth note steals the oldest (voice 0).
        do_reset();
        send(1'b1, 60, 100, lat);
        send(1'b1, 62, 100, lat);
        send(1'b1, 64, 100, lat);
        send(1'b1, 65, 100, lat);
        send(1'b1, 67, 90, lat);
        check("steal_pulse",   64'(vif.steal),                64'(1));
        check("steal_trigger", 64'(vif.voice_trigger),        64'(4'b0001));
        check("steal_release", 64'(vif.voice_release),        64'(0));
        check("steal_note0",   64'(vif.voice_note[NW-1:0]),   64'(67));

        // Existing note retriggers in place with the new velocity.
        send(1'b1, 62, 20, lat);
        check("retrig_trigger", 64'(vif.voice_trigger),             64'(4'b0010));
        check("retrig_steal",   64'(vif.steal),                     64'(0));
        check("retrig_vel1",    64'(vif.voice_velocity[2*VW-1:VW]), 64'(20));
        check("retrig_active",  64'(vif.voice_active),              64'(4'b1111));

        // Note-off keeps note/velocity; unknown note-off and velocity-0 note-on do nothing.
        send(1'b0, 64, 0, lat);
        check("off_release", 64'(vif.voice_release),             64'(4'b0100));
        check("off_active",  64'(vif.voice_active),              64'(4'b1011));
        check("off_note2",   64'(vif.voice_note[3*NW-1:2*NW]),   64'(64));
        send(1'b0, 99, 0, lat);
        check("off99_release", 64'(vif.voice_release), 64'(0));
        check("off99_active",  64'(vif.voice_active),  64'(4'b1011));
        send(1'b1, 70, 0, lat);
        check("vel0_trigger", 64'(vif.voice_trigger), 64'(0));
        check("vel0_release", 64'(vif.voice_release), 64'(0));
        check("vel0_active",  64'(vif.voice_active),  64'(4'b1011));

        // Free voice 2 is reused, then the oldest (voice 3 after the retrigger) is stolen.
        send(1'b1, 72, 9, lat);
        check("reuse_trigger", 64'(vif.voice_trigger), 64'(4'b0100));
        check("reuse_steal",   64'(vif.steal),         64'(0));
        send(1'b1, 74, 9, lat);
        check("age_trigger", 64'(vif.voice_trigger),           64'(4'b1000));
        check("age_steal",   64'(vif.steal),                   64'(1));
        check("age_note3",   64'(vif.voice_note[4*NW-1:3*NW]), 64'(74));

        // all_notes_off in the middle of a scan.
        do_reset();
        send(1'b1, 40, 50, lat);
        send(1'b1, 41, 50, lat);
        send(1'b1, 42, 50, lat);
        drive(1'b1, 43, 50);
        wait_accept();
        repeat (2) @(posedge clk);
        #1;
        vif.all_notes_off = 1'b1;
        @(posedge clk);
        #1;
        check("ano_release", 64'(vif.voice_release), 64'(4'b0111));
        check("ano_active",  64'(vif.voice_active),  64'(0));
        check("ano_ready",   64'(vif.event_ready),   64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("ano_release_once", 64'(vif.voice_release), 64'(0));
        vif.all_notes_off = 1'b0;
        #1;
        check("ano_ready_after", 64'(vif.event_ready), 64'(1));
        trig_seen = '0;
        for (int i = 0; i < VC + 4; i++) begin
            @(posedge clk);
            #1;
            trig_seen = trig_seen | vif.voice_trigger;
        end
        check("ano_dropped_event", 64'(trig_seen),        64'(0));
        check("ano_active_later",  64'(vif.voice_active), 64'(0));

        // Asynchronous reset during APPLY.
        send(1'b1, 50, 30, lat);
        send(1'b1, 51, 30, lat);
        drive(1'b1, 55, 60);
        wait_accept();
        repeat (VC) @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check("arst_active",   64'(vif.voice_active),   64'(0));
        check("arst_note",     64'(vif.voice_note),     64'(0));
        check("arst_velocity", 64'(vif.voice_velocity), 64'(0));
        check("arst_trigger",  64'(vif.voice_trigger),  64'(0));
        check("arst_release",  64'(vif.voice_release),  64'(0));
        check("arst_steal",    64'(vif.steal),          64'(0));
        check("arst_ready",    64'(vif.event_ready),    64'(1));
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        send(1'b1, 77, 5, lat);
        check("post_rst_trigger", 64'(vif.voice_trigger),      64'(4'b0001));
        check("post_rst_note0",   64'(vif.voice_note[NW-1:0]), 64'(77));
        check("post_rst_active",  64'(vif.voice_active),       64'(4'b0001));

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
